// File: rtl/hv_sw_serial_receiver.sv
// HV switch-chain serial receiver: oversamples CLK/DOUT/LE/CLR, shifts frames MSB first, latches on LE rise.
// Latency: SCLK rise acted on 3 clk_in cycles after the pin edge; sw_state/sw_valid 4 cycles after the LE pin rise.
// No backpressure: the serial source is free-running and the sw_valid pulse is not acknowledged.
module hv_sw_serial_receiver #(
    parameter int CHAIN_BITS = 32,
    parameter int CNT_W      = 7
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic                  HV_SW_CLR,
    input  logic                  HV_SW_LE,
    input  logic                  HV_SW_CLK,
    input  logic                  HV_SW_DOUT,
    input  logic                  err_clr,
    output logic [CHAIN_BITS-1:0] sw_state,
    output logic                  sw_valid,
    output logic [CNT_W-1:0]      bit_cnt,
    output logic                  frame_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    localparam logic [CNT_W-1:0] CHAIN_CNT = CNT_W'(CHAIN_BITS);

    state_t                  state, state_nx;
    logic [1:0]              clr_sy, dout_sy;
    logic [2:0]              le_sy, sclk_sy;
    logic [CHAIN_BITS-1:0]   shreg;
    logic                    clr_s, dout_s, sclk_rise, le_rise;
    logic                    do_shift, do_latch;

    // CLR and DOUT are used as levels, so they skip the edge-detect flop.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            clr_sy  <= '0;
            dout_sy <= '0;
            le_sy   <= '0;
            sclk_sy <= '0;
        end else begin
            clr_sy  <= {clr_sy[0], HV_SW_CLR};
            dout_sy <= {dout_sy[0], HV_SW_DOUT};
            le_sy   <= {le_sy[1:0], HV_SW_LE};
            sclk_sy <= {sclk_sy[1:0], HV_SW_CLK};
        end
    end

    assign clr_s     = clr_sy[1];
    assign dout_s    = dout_sy[1];
    assign sclk_rise = sclk_sy[1] & ~sclk_sy[2];
    assign le_rise   = le_sy[1] & ~le_sy[2];

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        do_shift = 1'b0;
        do_latch = 1'b0;
        if (clr_s) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    do_shift = sclk_rise;
                    if (le_rise)        state_nx = LATCH;
                    else if (sclk_rise) state_nx = SHIFT;
                end
                SHIFT: begin
                    do_shift = sclk_rise;
                    if (le_rise) state_nx = LATCH;
                end
                LATCH: begin
                    // A shift arriving during the latch cycle opens the next frame.
                    do_latch = 1'b1;
                    do_shift = sclk_rise;
                    state_nx = sclk_rise ? SHIFT : IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            shreg    <= '0;
            sw_state <= '0;
            sw_valid <= 1'b0;
            bit_cnt  <= '0;
        end else if (clr_s) begin
            shreg    <= '0;
            sw_state <= '0;
            sw_valid <= 1'b0;
            bit_cnt  <= '0;
        end else begin
            sw_valid <= do_latch;
            if (do_shift) begin
                shreg <= {shreg[CHAIN_BITS-2:0], dout_s};
            end
            if (do_latch) begin
                sw_state <= shreg;
                bit_cnt  <= do_shift ? CNT_W'(1) : '0;
            end else if (do_shift && !(&bit_cnt)) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Sticky length error; a same-cycle error latch beats err_clr, and CLR leaves it alone.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
        end else if (do_latch && (bit_cnt != CHAIN_CNT)) begin
            frame_err <= 1'b1;
        end else if (err_clr) begin
            frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hv_sw_serial_receiver.sv
// Directed bench for hv_sw_serial_receiver: nominal, short/long frames, CLR priority, coincident edges, reset mid-frame.
`timescale 1ns/1ps
module tb_hv_sw_serial_receiver;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        HV_SW_CLR, HV_SW_LE, HV_SW_CLK, HV_SW_DOUT, err_clr;
    logic [31:0] sw_state;
    logic        sw_valid;
    logic [6:0]  bit_cnt;
    logic        frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int vcnt = 0;
    int vdouble = 0;
    logic prev_v = 1'b0;

    hv_sw_serial_receiver #(.CHAIN_BITS(32), .CNT_W(7)) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .HV_SW_CLR  (HV_SW_CLR),
        .HV_SW_LE   (HV_SW_LE),
        .HV_SW_CLK  (HV_SW_CLK),
        .HV_SW_DOUT (HV_SW_DOUT),
        .err_clr    (err_clr),
        .sw_state   (sw_state),
        .sw_valid   (sw_valid),
        .bit_cnt    (bit_cnt),
        .frame_err  (frame_err)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (sw_valid) vcnt++;
        if (sw_valid && prev_v) vdouble++;
        prev_v = sw_valid;
    end

    task automatic send_bit(input logic b);
        HV_SW_DOUT = b;
        #40 HV_SW_CLK = 1'b1;
        #40 HV_SW_CLK = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(data[i]);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        #10 err_clr = 1'b0;
        #20;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; HV_SW_CLR = 0; HV_SW_LE = 0; HV_SW_CLK = 0; HV_SW_DOUT = 0; err_clr = 0;
        repeat (3) begin
            HV_SW_DOUT = 1'b1;
            #40 HV_SW_CLK = 1'b1;
            #40 HV_SW_CLK = 1'b0;
        end
        n_cmp++;
        if (bit_cnt !== 7'd0) begin n_bad++; $display("FAIL rst_sclk_cnt: got %0d want 0", bit_cnt); end
        #160 reset_n = 1'b1;
        #50;
        n_cmp++;
        if (sw_state !== 32'h0) begin n_bad++; $display("FAIL rst_state: got %h want 0", sw_state); end
        n_cmp++;
        if ({sw_valid, frame_err, bit_cnt} !== 9'd0) begin
            n_bad++; $display("FAIL rst_flags: got v=%b e=%b c=%0d want 0/0/0", sw_valid, frame_err, bit_cnt);
        end
    endtask

    task automatic test_nominal();
        int v0;
        v0 = vcnt;
        send_word(64'hA5C30F81, 32);
        n_cmp++;
        if (bit_cnt !== 7'd32) begin n_bad++; $display("FAIL nom_cnt: got %0d want 32", bit_cnt); end
        HV_SW_LE = 1'b1;
        #40;
        n_cmp++;
        if (sw_state !== 32'hA5C30F81) begin n_bad++; $display("FAIL nom_state: got %h want a5c30f81", sw_state); end
        n_cmp++;
        if (sw_valid !== 1'b1) begin n_bad++; $display("FAIL nom_valid: got %b want 1", sw_valid); end
        HV_SW_LE = 1'b0;
        #40;
        n_cmp++;
        if (vcnt - v0 !== 1) begin n_bad++; $display("FAIL nom_pulses: got %0d want 1", vcnt - v0); end
        n_cmp++;
        if (frame_err !== 1'b0) begin n_bad++; $display("FAIL nom_err: got %b want 0", frame_err); end
        n_cmp++;
        if (bit_cnt !== 7'd0) begin n_bad++; $display("FAIL nom_cnt_clr: got %0d want 0", bit_cnt); end
    endtask

    task automatic test_short_frame();
        int v0;
        v0 = vcnt;
        send_word(64'h12345678, 31);
        HV_SW_LE = 1'b1; #40 HV_SW_LE = 1'b0; #40;
        n_cmp++;
        if (frame_err !== 1'b1) begin n_bad++; $display("FAIL short_err: got %b want 1", frame_err); end
        n_cmp++;
        if (vcnt - v0 !== 1) begin n_bad++; $display("FAIL short_pulses: got %0d want 1", vcnt - v0); end
        n_cmp++;
        if (sw_state !== 32'h92345678) begin n_bad++; $display("FAIL short_state: got %h want 92345678", sw_state); end
        send_word(64'h0F0F1234, 32);
        HV_SW_LE = 1'b1; #40 HV_SW_LE = 1'b0; #40;
        n_cmp++;
        if (frame_err !== 1'b1) begin n_bad++; $display("FAIL short_sticky: got %b want 1", frame_err); end
        pulse_err_clr();
        n_cmp++;
        if (frame_err !== 1'b0) begin n_bad++; $display("FAIL short_errclr: got %b want 0", frame_err); end
    endtask

    task automatic test_long_frame();
        send_word(64'h1, 1);
        send_word(64'hFFFF0000, 32);
        n_cmp++;
        if (bit_cnt !== 7'd33) begin n_bad++; $display("FAIL long_cnt: got %0d want 33", bit_cnt); end
        HV_SW_LE = 1'b1; #40 HV_SW_LE = 1'b0; #40;
        n_cmp++;
        if (sw_state !== 32'hFFFF0000) begin n_bad++; $display("FAIL long_state: got %h want ffff0000", sw_state); end
        n_cmp++;
        if (frame_err !== 1'b1) begin n_bad++; $display("FAIL long_err: got %b want 1", frame_err); end
        pulse_err_clr();
    endtask

    task automatic test_clr_priority();
        int v0;
        send_word(64'h12345678, 32);
        HV_SW_LE = 1'b1; #40 HV_SW_LE = 1'b0; #40;
        n_cmp++;
        if (sw_state !== 32'h12345678) begin n_bad++; $display("FAIL clr_pre_state: got %h want 12345678", sw_state); end
        send_word(64'h5, 3);
        v0 = vcnt;
        HV_SW_CLR = 1'b1; HV_SW_LE = 1'b1;
        #30;
        n_cmp++;
        if (sw_state !== 32'h0) begin n_bad++; $display("FAIL clr_state: got %h want 0", sw_state); end
        #30 HV_SW_LE = 1'b0;
        #40 HV_SW_CLR = 1'b0;
        #40;
        n_cmp++;
        if (vcnt - v0 !== 0) begin n_bad++; $display("FAIL clr_no_valid: got %0d pulses want 0", vcnt - v0); end
        n_cmp++;
        if (bit_cnt !== 7'd0) begin n_bad++; $display("FAIL clr_cnt: got %0d want 0", bit_cnt); end
        n_cmp++;
        if (frame_err !== 1'b0) begin n_bad++; $display("FAIL clr_err_kept: got %b want 0", frame_err); end
        // Zero-bit latch from IDLE still pulses and flags the length.
        HV_SW_LE = 1'b1;
        #40;
        n_cmp++;
        if (sw_valid !== 1'b1) begin n_bad++; $display("FAIL zero_valid: got %b want 1", sw_valid); end
        HV_SW_LE = 1'b0;
        #40;
        n_cmp++;
        if ({frame_err, sw_state} !== {1'b1, 32'h0}) begin
            n_bad++; $display("FAIL zero_latch: got e=%b s=%h want 1/0", frame_err, sw_state);
        end
        pulse_err_clr();
    endtask

    task automatic test_coincident();
        send_word(64'h13579BDF >> 1, 31);
        HV_SW_DOUT = 1'b1;
        #40 HV_SW_CLK = 1'b1; HV_SW_LE = 1'b1;
        #40;
        n_cmp++;
        if (sw_state !== 32'h13579BDF) begin n_bad++; $display("FAIL coin_state: got %h want 13579bdf", sw_state); end
        HV_SW_CLK = 1'b0; HV_SW_LE = 1'b0;
        #40;
        n_cmp++;
        if (frame_err !== 1'b0) begin n_bad++; $display("FAIL coin_err: got %b want 0", frame_err); end
    endtask

    task automatic test_reset_mid_frame();
        send_word(64'hCAFEBABE >> 22, 10);
        reset_n = 1'b0;
        #20;
        n_cmp++;
        if ({sw_state, sw_valid, bit_cnt, frame_err} !== 41'd0) begin
            n_bad++; $display("FAIL midrst_out: got s=%h c=%0d e=%b want 0", sw_state, bit_cnt, frame_err);
        end
        #40 reset_n = 1'b1;
        #40;
        send_word(64'hCAFEBABE, 32);
        HV_SW_LE = 1'b1; #40 HV_SW_LE = 1'b0; #40;
        n_cmp++;
        if (sw_state !== 32'hCAFEBABE) begin n_bad++; $display("FAIL midrst_state: got %h want cafebabe", sw_state); end
        n_cmp++;
        if (frame_err !== 1'b0) begin n_bad++; $display("FAIL midrst_err: got %b want 0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_frame();
        test_long_frame();
        test_clr_priority();
        test_coincident();
        test_reset_mid_frame();
        n_cmp++;
        if (vdouble !== 0) begin n_bad++; $display("FAIL valid_double: got %0d back-to-back want 0", vdouble); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hv_sw_serial_receiver.md
Name: hv_sw_serial_receiver

Overview:
Receive-side counterpart of the transmit entity's high-voltage switch serial port (HV_SW_CLK/HV_SW_DOUT/HV_SW_LE/HV_SW_CLR). It oversamples the serial lines in the clk_in domain, deserializes the switch-chain frame and latches it into a parallel switch-state register on LE. It also checks frame length. The block serves as the synthesizable switch-chain emulator for transmit bring-up and as the reference responder in the transmit testbench.

Parameters:
CHAIN_BITS, 32, switch-chain length in bits (one bit per HV switch); legal range 2..64.
CNT_W, 7, bit-counter width; must satisfy 2^CNT_W-1 > CHAIN_BITS.

Ports:
clk_in  input  1  system clock (100 MHz in the bench).
reset_n  input  1  asynchronous active-low reset.
HV_SW_CLR  input  1  switch clear, active high, asynchronous to clk_in.
HV_SW_LE  input  1  latch enable; the rising edge latches the frame.
HV_SW_CLK  input  1  serial clock; the rising edge shifts in data.
HV_SW_DOUT  input  1  serial data, MSB first.
sw_state  output  CHAIN_BITS  latched switch states; bit CHAIN_BITS-1 is the first bit shifted.
sw_valid  output  1  one-cycle pulse when sw_state is updated by a latch.
bit_cnt  output  CNT_W  SCLK edges received since the last latch or clear; saturating.
frame_err  output  1  sticky flag: a latch occurred with bit_cnt != CHAIN_BITS.
err_clr  input  1  synchronous clear of frame_err.

Behaviour:
- Reset values (async, reset_n=0): sw_state=0, sw_valid=0, bit_cnt=0, frame_err=0, shift register=0, synchronizers=0, FSM=IDLE.
- Synchronization: CLR, LE, SCLK and DOUT each pass through a 2-flop synchronizer, plus a third flop for edge detect. DOUT is delayed identically so it stays aligned with SCLK.
- Latency: a pin-level SCLK rise is acted on 3 clk_in cycles later.
- Input timing requirements: SCLK high ≥3 clk_in cycles and low ≥3 clk_in cycles. DOUT setup ≥1 cycle and hold ≥2 cycles around the SCLK rise.
- Shift: on a synchronized SCLK rise, shreg <= {shreg[CHAIN_BITS-2:0], dout_s}. bit_cnt increments, saturating at 2^CNT_W-1.
- FSM states:
  - IDLE: bit_cnt=0. A SCLK rise moves to SHIFT.
  - SHIFT: accumulating bits. An LE rise moves to LATCH.
  - LATCH: one cycle. sw_state<=shreg; sw_valid=1; frame_err|=(bit_cnt!=CHAIN_BITS); bit_cnt<=0; next state is IDLE.
- LE rise while in IDLE (zero bits): the latch still occurs. sw_state<=shreg (unchanged content), frame_err is set, sw_valid pulses.
- SCLK rise and LE rise in the same cycle: the shift is applied first, and the latched value includes that bit. The count check uses the incremented count.
- More than CHAIN_BITS bits shifted: the oldest bits fall off the top, so sw_state holds the last CHAIN_BITS bits. frame_err is set at the latch.
- CLR: while the synchronized CLR is high, sw_state=0, shreg=0, bit_cnt=0, FSM=IDLE, and shifts and latches are ignored. CLR dominates a simultaneous LE rise: no sw_valid pulse. frame_err is unaffected by CLR.
- err_clr: clears frame_err. If an error latch occurs in the same cycle, the set wins.
- sw_valid is high exactly one cycle per latch and never two consecutive cycles, because LE high must persist ≥3 cycles.
- Reset mid-frame: all state is dropped immediately. The first SCLK rise after reset release starts a fresh frame.

Test Plan:
- Reset: hold reset_n=0 for 400 ns, then release -> all outputs 0. Toggling SCLK during reset produces no bit_cnt change.
- Nominal frame (CHAIN_BITS=32): SCLK period 80 ns, shift 0xA5C3_0F81 MSB first, then LE pulse 40 ns -> bit_cnt=32 before the latch; sw_state=32'hA5C30F81 within 4 cycles of the LE rise; one sw_valid pulse; frame_err=0; bit_cnt returns to 0.
- Short frame: shift 31 bits then LE -> frame_err=1 and sw_valid pulses. A second, correct 32-bit frame keeps frame_err=1 until err_clr=1 for one cycle, after which frame_err=0.
- Long frame: shift 0x1 followed by 32 bits of 0xFFFF_0000, then LE -> sw_state=32'hFFFF0000, frame_err=1.
- CLR priority: latch 0x12345678, then raise CLR and LE together -> sw_state=0 within 3 cycles, no sw_valid. After CLR drops, bit_cnt=0.
- Coincident edge: align the 32nd SCLK rise with the LE rise -> latched value includes the 32nd bit and frame_err=0. Assert reset_n=0 mid-frame (bit 10) -> outputs 0; the next full frame latches correctly.
